alu_resp_unit: RTL and testbench

- Execute-stage responder that sits between the issue logic and the ALU function set.
- Accepts one ALU operation per valid/ready request, computes it, and returns a registered result with overflow and error flags on a valid/ready response channel.
- Single-cycle ops have one-cycle latency.
- Adds a multi-cycle unsigned multiply (af=1100) using the same handshake, so issue logic sees a uniform interface.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb_core.sv | 54 +++++
 rtl/alu_resp_unit.sv | 141 ++++++++++++++
 tb/tb_alu_resp_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU response unit: function codes and FSM states.
package alu_pkg;

  // Function codes understood by the unit
  localparam logic [3:0] AF_ADD     = 4'b0000;
  localparam logic [3:0] AF_SUB     = 4'b0010;
  localparam logic [3:0] AF_AND     = 4'b0100;
  localparam logic [3:0] AF_OR      = 4'b0101;
  localparam logic [3:0] AF_XOR     = 4'b0110;
  localparam logic [3:0] AF_NOR_LUI = 4'b0111;
  localparam logic [3:0] AF_SLT     = 4'b1010;
  localparam logic [3:0] AF_MUL     = 4'b1100;

  // Control FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  // The multiply is the only code that does not finish in one cycle
  function automatic logic is_multicycle(input logic [3:0] af);
    return (af == AF_MUL);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purely combinational evaluation of all single-cycle function codes.
// The multiply code is reported as supported with a zero result; the
// caller routes it to the iterative datapath instead.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   af_i,
  input  logic         imm_i,
  output logic [N-1:0] res_o,
  output logic         ovf_o,
  output logic         err_o
);

  logic [N-1:0] sum;
  logic [N-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  // Select the result and flags for the requested function code
  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    err_o = 1'b0;
    case (af_i)
      AF_ADD: begin
        res_o = sum;
        ovf_o = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      AF_SUB: begin
        res_o = diff;
        ovf_o = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
      end
      AF_AND: res_o = a_i & b_i;
      AF_OR:  res_o = a_i | b_i;
      AF_XOR: res_o = a_i ^ b_i;
      AF_NOR_LUI: begin
        if (imm_i) begin
          res_o = {b_i[15:0], {(N-16){1'b0}}};
        end else begin
          res_o = ~(a_i | b_i);
        end
      end
      AF_SLT: res_o = ($signed(a_i) < $signed(b_i)) ? '1 : '0;
      AF_MUL: res_o = '0;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_resp_unit.sv
// Execute-stage responder: accepts one ALU op per request handshake and
// returns a registered result on a response handshake. Single-cycle ops
// answer on the next cycle; unsigned multiply iterates shift-add for N
// cycles plus one cycle to register the product.
module alu_resp_unit
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic [3:0]   req_af,
  input  logic         req_i,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_res,
  output logic         rsp_ovf,
  output logic         rsp_err
);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;      // {partial product high, multiplier low}
  logic [N-1:0]   mcand_q, mcand_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [N-1:0]   rsp_res_q, rsp_res_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_err_q, rsp_err_d;

  logic           accept;
  logic [N-1:0]   core_res;
  logic           core_ovf;
  logic           core_err;
  logic [N-1:0]   addend;
  logic [N:0]     step_sum;

  alu_comb_core #(.N(N)) u_core (
    .a_i   (req_a),
    .b_i   (req_b),
    .af_i  (req_af),
    .imm_i (req_i),
    .res_o (core_res),
    .ovf_o (core_ovf),
    .err_o (core_err)
  );

  // A held response that is being consumed frees the unit on the same edge
  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  // One shift-add step: add the multiplicand when the current multiplier
  // bit is set, keeping the carry so nothing is lost before the shift
  assign addend   = acc_q[0] ? mcand_q : '0;
  assign step_sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, addend};

  // Next-state, multiply datapath and response-register load logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      MUL: begin
        if (cnt_q == CW'(N)) begin
          // All N steps done: publish the low half, flag a non-zero high half
          rsp_res_d   = acc_q[N-1:0];
          rsp_ovf_d   = |acc_q[2*N-1:N];
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          acc_d = {step_sum, acc_q[N-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // A new request overrides the drain above, giving bubble-free streaming
    if (accept) begin
      if (is_multicycle(req_af)) begin
        mcand_d     = req_a;
        acc_d       = {{N{1'b0}}, req_b};
        cnt_d       = '0;
        rsp_valid_d = 1'b0;
        state_d     = MUL;
      end else begin
        rsp_res_d   = core_res;
        rsp_ovf_d   = core_ovf;
        rsp_err_d   = core_err;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
    end
  end

  // State, datapath and response registers; reset drops any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_resp_unit.sv
// Directed bench for alu_resp_unit with an expected-response queue.
module tb_alu_resp_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [N-1:0] req_a = '0;
  logic [N-1:0] req_b = '0;
  logic [3:0]   req_af = '0;
  logic         req_i = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_res;
  logic         rsp_ovf;
  logic         rsp_err;

  typedef struct packed {
    logic [N-1:0] res;
    logic         ovf;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   transfers = 0;
  int   last_wait = 0;

  logic         hold_v = 1'b0;
  logic [N+1:0] hold_val = '0;

  alu_resp_unit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_af    (req_af),
    .req_i     (req_i),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed with wide signed/unsigned arithmetic
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [3:0] af, input logic i);
    exp_t   e;
    longint s;
    logic [63:0] p;
    e = '0;
    case (af)
      4'b0000: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.res = a + b;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0010: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.res = a - b;
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100: e.res = a & b;
      4'b0101: e.res = a | b;
      4'b0110: e.res = a ^ b;
      4'b0111: e.res = i ? {b[15:0], 16'h0000} : ~(a | b);
      4'b1010: e.res = ($signed(a) < $signed(b)) ? 32'hFFFF_FFFF : 32'h0;
      4'b1100: begin
        p = {32'h0, a} * {32'h0, b};
        e.res = p[31:0];
        e.ovf = (p[63:32] != 32'h0);
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Response monitor: compare every transfer, and check stability while stalled
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && rsp_valid) begin
        chk("stall_stable", {30'h0, rsp_res, rsp_ovf, rsp_err}, {30'h0, hold_val});
      end
      hold_v   = rsp_valid && !rsp_ready;
      hold_val = {rsp_res, rsp_ovf, rsp_err};
      if (rsp_valid && rsp_ready) begin
        transfers++;
        chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_res", 64'(rsp_res), 64'(e.res));
          chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          $display("rsp res=%h ovf=%0b err=%0b", rsp_res, rsp_ovf, rsp_err);
        end
      end
    end
  end

  // Present a request and hold it until accepted; leaves req_valid asserted
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] af, input logic i);
    int waits;
    waits     = 0;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_af    = af;
    req_i     = i;
    sb.push_back(model(a, b, af, i));
    $display("req a=%h b=%h af=%b i=%0b", a, b, af, i);
    while (waits < 200) begin
      @(negedge clk);
      if (req_ready) break;
      waits++;
    end
    if (waits >= 200) chk("req_accept_timeout", 64'(waits), 64'd0);
    last_wait = waits;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int k;

    // Reset state
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_res", 64'(rsp_res), 64'd0);
    chk("rst_ovf", 64'(rsp_ovf), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", 64'(req_ready), 64'd1);

    // Add overflow
    rsp_ready = 1'b1;
    issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 1'b0);
    idle(2);

    // Back-pressure on a subtract
    rsp_ready = 1'b0;
    t0 = transfers;
    issue(32'h0000_00A5, 32'h0000_005A, 4'b0010, 1'b0);
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_res", 64'(rsp_res), 64'h4B);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_one_transfer", 64'(transfers - t0), 64'd1);
    chk("bp_drained", 64'(rsp_valid), 64'd0);

    // Streaming logic ops, one per cycle
    t0 = transfers;
    issue(32'hAAAA_AAAA, 32'h5555_5555, 4'b0100, 1'b0);
    issue(32'hAAAA_AAAA, 32'h5555_5555, 4'b0101, 1'b0);
    chk("stream_nobubble", 64'(last_wait), 64'd0);
    issue(32'hAAAA_AAAA, 32'h5555_5555, 4'b0110, 1'b0);
    chk("stream_nobubble", 64'(last_wait), 64'd0);
    issue(32'hAAAA_AAAA, 32'h5555_5555, 4'b0111, 1'b0);
    chk("stream_nobubble", 64'(last_wait), 64'd0);
    issue(32'hAAAA_AAAA, 32'h5555_5555, 4'b0111, 1'b1);
    chk("stream_nobubble", 64'(last_wait), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("stream_count", 64'(transfers - t0), 64'd4);
    @(posedge clk); #1;
    chk("stream_count", 64'(transfers - t0), 64'd5);

    // Multiply latency and results
    idle(1);
    issue(32'h0001_0000, 32'h0001_0001, 4'b1100, 1'b0);
    req_valid = 1'b0;
    k = 0;
    while (k < 60) begin
      @(posedge clk); #1;
      k++;
      if (rsp_valid) break;
    end
    chk("mul_latency", 64'(k), 64'd33);
    idle(2);
    issue(32'h0000_FFFF, 32'h0000_0002, 4'b1100, 1'b0);
    idle(40);

    // Unsupported code and signed compare
    issue(32'h1234_5678, 32'h9ABC_DEF0, 4'b1111, 1'b0);
    issue(32'h0000_0001, 32'h0000_0002, 4'b1010, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 4'b1010, 1'b0);
    issue(32'h0000_0002, 32'h0000_0001, 4'b1010, 1'b0);
    issue(32'h8000_0000, 32'h0000_0001, 4'b0010, 1'b0);
    idle(3);

    // Reset in the middle of a multiply drops it silently
    issue(32'h0000_0003, 32'h0000_0005, 4'b1100, 1'b0);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midmul_rst_valid", 64'(rsp_valid), 64'd0);
    sb.delete();
    #3 rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    t0 = transfers;
    idle(40);
    chk("no_stale_rsp", 64'(transfers - t0), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
